bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter that feeds the per-digit hex/seven-segment decoders driving the six DE10-Lite displays (HEX0–HEX5). It accepts an unsigned binary word over a valid/ready handshake and converts it with shift-and-add-3 (double dabble), one bit per clock. It then presents DIGITS registered 4-bit BCD nibbles; each nibble drives one decoder's {a,b,c,d} inputs, MSB first.

---
 rtl/bin2bcd_seq_if.sv | 35 +++
 rtl/bin2bcd_seq.sv | 161 ++++++++++++++++
 tb/tb_bin2bcd_seq.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if
//   Handshake and result bundle for the sequential binary-to-BCD converter.
//   master : producer/consumer side (drives in_valid, bin_in; observes results)
//   slave  : the converter itself
// Signals:
//   in_valid/in_ready : word handshake, transfer when both high at clk rise
//   bin_in            : WIDTH-bit unsigned binary word
//   bcd_out           : DIGITS packed BCD nibbles, digit 0 in bits [3:0]
//   out_valid         : one-cycle pulse when bcd_out/overflow/blank update
//   overflow          : last result saturated to all nines
//   blank             : leading-zero mask, one bit per digit
//   busy              : conversion in progress (inverse of in_ready)
interface bin2bcd_seq_if #(
    parameter int WIDTH  = 20,
    parameter int DIGITS = 6
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      bin_in;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  out_valid;
    logic                  overflow;
    logic [DIGITS-1:0]     blank;
    logic                  busy;

    modport master (
        output in_valid, bin_in,
        input  in_ready, bcd_out, out_valid, overflow, blank, busy
    );

    modport slave (
        input  in_valid, bin_in,
        output in_ready, bcd_out, out_valid, overflow, blank, busy
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
//   Double-dabble (shift-and-add-3) binary-to-BCD converter, one input bit
//   per clock. Results feed per-digit seven-segment decoders, so every
//   output is registered and held until the next conversion completes.
//   Inputs at or above 10^DIGITS saturate to all nines with overflow set.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : bin2bcd_seq_if.slave (handshake, binary in, BCD/flags out)
// Configuration:
//   BIN2BCD_BLANK_EN : when defined, blank[] marks leading-zero digits
//                      (digit 0 never blanked, nothing blanked on overflow);
//                      when undefined, blank is tied low.

// One BCD digit's add-3 correction, applied before each left shift.
module bin2bcd_seq_nib (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bin2bcd_seq #(
    parameter int WIDTH  = 20,
    parameter int DIGITS = 6
) (
    input  logic          clk,
    input  logic          reset,
    bin2bcd_seq_if.slave  bus
);
    // Wide enough that 10^DIGITS (< 2^(4*DIGITS)) and bin_in never truncate.
    localparam int CW    = WIDTH + 4*DIGITS;
    localparam int CNT_W = $clog2(WIDTH);

    function automatic logic [CW-1:0] pow10(input int n);
        logic [CW-1:0] p;
        p = CW'(1);
        for (int k = 0; k < n; k++) p = p * CW'(10);
        return p;
    endfunction

    localparam logic [CW-1:0]    LIMIT = pow10(DIGITS);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH-1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                    state, state_nxt;
    logic [WIDTH-1:0]          shreg;
    logic [DIGITS-1:0][3:0]    scratch;
    logic [DIGITS-1:0][3:0]    adj;
    logic [4*DIGITS-1:0]       adj_flat;
    logic [CNT_W-1:0]          cnt;
    logic                      ovf_pending;
    logic [DIGITS-1:0][3:0]    bcd_q;
    logic                      ovf_q;
    logic                      out_valid_q;
    logic                      in_ready_q;
    logic                      busy_q;

    // Per-digit correction lanes.
    for (genvar i = 0; i < DIGITS; i++) begin : g_nib
        bin2bcd_seq_nib u_nib (.d(scratch[i]), .q(adj[i]));
    end
    assign adj_flat = adj;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = SHIFT;
            SHIFT:   if (cnt == LAST)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q;

    // Digit i blanks when it and every digit above it are zero; digit 0
    // always shows so that the value zero renders as a single "0".
    function automatic logic [DIGITS-1:0] blank_of(input logic [DIGITS-1:0][3:0] v);
        logic [DIGITS-1:0] b;
        logic              z;
        b = '0;
        z = 1'b1;
        for (int i = DIGITS-1; i >= 1; i--) begin
            z    = z & (v[i] == 4'd0);
            b[i] = z;
        end
        return b;
    endfunction
`endif

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg       <= '0;
            scratch     <= '0;
            cnt         <= '0;
            ovf_pending <= 1'b0;
            bcd_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
            blank_q     <= blank_of('0);
`endif
        end else begin
            out_valid_q <= 1'b0;
            // Registered decode of the next state keeps both flags glitch-free.
            in_ready_q  <= (state_nxt == IDLE);
            busy_q      <= (state_nxt != IDLE);
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        shreg       <= bus.bin_in;
                        scratch     <= '0;
                        cnt         <= '0;
                        ovf_pending <= (CW'(bus.bin_in) >= LIMIT);
                    end
                end
                SHIFT: begin
                    // Correct, then shift {scratch, shreg} left by one; the
                    // top scratch bit falls off, covered by ovf_pending.
                    scratch <= {adj_flat[4*DIGITS-2:0], shreg[WIDTH-1]};
                    shreg   <= {shreg[WIDTH-2:0], 1'b0};
                    cnt     <= cnt + CNT_W'(1);
                end
                DONE: begin
                    out_valid_q <= 1'b1;
                    ovf_q       <= ovf_pending;
                    if (ovf_pending) bcd_q <= {DIGITS{4'h9}};
                    else             bcd_q <= scratch;
`ifdef BIN2BCD_BLANK_EN
                    blank_q <= ovf_pending ? '0 : blank_of(scratch);
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.overflow  = ovf_q;
    assign bus.bcd_out   = bcd_q;
`ifdef BIN2BCD_BLANK_EN
    assign bus.blank     = blank_q;
`else
    assign bus.blank     = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq
//   Directed and randomized checks of bin2bcd_seq against a decimal
//   reference model (plain division/modulo).
module tb_bin2bcd_seq;
    localparam int W = 20;
    localparam int D = 6;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bin2bcd_seq_if #(.WIDTH(W), .DIGITS(D)) bus ();
    bin2bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint unsigned m_limit();
        longint unsigned l = 1;
        for (int i = 0; i < D; i++) l = l * 10;
        return l;
    endfunction

    function automatic logic m_ovf(input longint unsigned v);
        return v >= m_limit();
    endfunction

    function automatic logic [4*D-1:0] m_bcd(input longint unsigned v);
        logic [4*D-1:0] r;
        longint unsigned t = v;
        for (int i = 0; i < D; i++) begin
            if (m_ovf(v)) r[4*i +: 4] = 4'd9;
            else begin
                r[4*i +: 4] = 4'(t % 10);
                t = t / 10;
            end
        end
        return r;
    endfunction

    function automatic logic [D-1:0] m_blank(input longint unsigned v);
        logic [D-1:0] b = '0;
`ifdef BIN2BCD_BLANK_EN
        int ndig = 1;
        longint unsigned t = v / 10;
        while (t > 0) begin ndig++; t = t / 10; end
        if (!m_ovf(v))
            for (int i = 0; i < D; i++) b[i] = (i >= ndig);
`endif
        return b;
    endfunction

    task automatic check_result(input string tag, input longint unsigned v);
        check({tag, "_bcd"},   64'(bus.bcd_out),  64'(m_bcd(v)));
        check({tag, "_ovf"},   64'(bus.overflow), 64'(m_ovf(v)));
        check({tag, "_blank"}, 64'(bus.blank),    64'(m_blank(v)));
    endtask

    // Wait (bounded) for out_valid; returns negedges elapsed since the
    // negedge that follows the acceptance edge. Optional stray in_valid pulse.
    task automatic wait_done(input bit inject, output int n);
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (inject && n == 5) begin bus.in_valid = 1'b1; bus.bin_in = 20'h12345; end
            else if (inject && n == 6) bus.in_valid = 1'b0;
            if (bus.out_valid) break;
        end
    endtask

    task automatic convert(input string tag, input int unsigned v, input bit inject);
        int n;
        n = 0;
        while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
        check({tag, "_ready"}, 64'(bus.in_ready), 64'(1));
        bus.bin_in   = W'(v);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({tag, "_busy"}, 64'(bus.busy), 64'(1));
        wait_done(inject, n);
        check({tag, "_latency"}, 64'(n), 64'(W+1));
        check_result(tag, longint'(v));
        @(negedge clk);
        check({tag, "_pulse"}, 64'(bus.out_valid), 64'(0));
        check({tag, "_idle"},  64'(bus.in_ready),  64'(1));
    endtask

    initial begin
        int n, low, pulses;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.bin_in   = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(bus.in_ready),  64'(1));
        check("rst_busy",  64'(bus.busy),      64'(0));
        check("rst_ov",    64'(bus.out_valid), 64'(0));
        check_result("rst", 0);
        reset = 1'b0;
        @(negedge clk);

        convert("zero",  0,        1'b0);
        convert("d123",  123456,   1'b1);
        convert("max",   999999,   1'b0);
        convert("lim",   1000000,  1'b0);
        convert("fff",   20'hFFFFF, 1'b0);
        for (int k = 0; k < 8; k++)
            convert("rnd", $urandom_range(0, (1 << W) - 1), 1'b0);
        for (int k = 0; k < 3; k++)
            convert("edge", 999990 + $urandom_range(0, 20), 1'b0);
        for (int k = 0; k < 3; k++)
            convert("small", $urandom_range(0, 999), 1'b0);

        // Back-to-back with in_valid held high.
        bus.bin_in   = W'(42);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.bin_in = W'(7);
        low = 0;
        n   = 0;
        while (!bus.in_ready && n < 100) begin low++; @(negedge clk); n++; end
        check("b2b_low",  64'(low), 64'(W+1));
        check("b2b_ov42", 64'(bus.out_valid), 64'(1));
        check_result("b2b42", 42);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("b2b_accept2", 64'(bus.in_ready), 64'(0));
        wait_done(1'b0, n);
        check("b2b_lat7", 64'(n), 64'(W+1));
        check_result("b2b7", 7);
        @(negedge clk);

        // Reset mid-conversion.
        bus.bin_in   = W'(500000);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_ready", 64'(bus.in_ready), 64'(1));
        check("abort_busy",  64'(bus.busy),     64'(0));
        check_result("abort", 0);
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            if (bus.out_valid) pulses++;
            @(negedge clk);
        end
        check("abort_nopulse", 64'(pulses), 64'(0));
        check("abort_hold", 64'(bus.bcd_out), 64'(0));
        convert("after", 31, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
